register_file_mp: RTL and testbench
===================================

Name: register_file_mp

Overview:
- Parametrised successor to the two-read/one-write register file.
- Generalised read-port count.
- Optional hardwired-zero register 0.
- Same-cycle write-to-read bypass.
- Sequential clear after reset: walks every location to zero and flags busy meanwhile.
- Sits in the CPU datapath between decode (read addresses) and writeback (write port).

Parameters:
- Nloc, 32, number of registers; power of 2, >=2.
- Dbits, 32, data width in bits.
- NREAD, 2, number of read ports, 1..4.
- ZERO_REG, 1, when 1 register 0 always reads 0 and writes to it are discarded.

Ports:
- clock  input  1  single clock, all state on posedge.
- reset  input  1  synchronous, active-high.
- wr  input  1  write enable.
- WriteAddr  input  $clog2(Nloc)  write address.
- WriteData  input  Dbits  write data.
- ReadAddr  input  NREAD*$clog2(Nloc)  packed read addresses; port i at slice [i*AW +: AW].
- ReadData  output  NREAD*Dbits  packed read data; port i at slice [i*Dbits +: Dbits].
- busy  output  1  high while the clear sequence runs; writes are ignored.

Behaviour:
- State machine, two states, RF_CLEAR and RF_RUN.
- reset=1 at a posedge:
  - state<=RF_CLEAR, clear counter<=0.
  - busy=1 on the next cycle.
  - ReadData driven 0 while in RF_CLEAR.
- RF_CLEAR:
  - Each cycle rf[cnt]<=0 and cnt<=cnt+1.
  - When cnt==Nloc-1 that location is zeroed and state<=RF_RUN.
  - Total Nloc cycles of busy after reset is released; busy falls the cycle after location Nloc-1 is written.
- Reset held high: FSM stays at cnt=0 in RF_CLEAR. Location 0 may be rewritten to 0 each cycle.
- Reset asserted mid-clear: counter restarts at 0 and the full Nloc-cycle clear repeats.
- wr during RF_CLEAR: dropped silently; no deferred write.
- RF_RUN write: if wr, rf[WriteAddr]<=WriteData at posedge, except when ZERO_REG && WriteAddr==0 (discarded).
- RF_RUN read, combinational, zero latency, evaluated per port in priority order:
  1. ZERO_REG && ReadAddr_i==0 -> 0.
  2. wr && WriteAddr==ReadAddr_i -> WriteData (bypass, same cycle).
  3. Otherwise rf[ReadAddr_i].
- Multiple read ports with the same address return identical data.
- Counter width is $clog2(Nloc); no wrap beyond Nloc-1 because the FSM leaves RF_CLEAR first.

Optional Feature:
- Macro: REGFILE_SCOREBOARD_EN.
- Enabled, extra ports:
  - reserve input 1.
  - ReserveAddr input $clog2(Nloc).
  - ReadPending output NREAD.
- Enabled, behaviour:
  - Nloc-bit pending vector, cleared to 0 during reset/RF_CLEAR.
  - In RF_RUN, reserve sets pending[ReserveAddr] at posedge.
  - An accepted write clears pending[WriteAddr].
  - reserve and write to the same address in the same cycle: set wins (new producer issued).
  - ReadPending[i] = pending[ReadAddr_i] && !(wr && WriteAddr==ReadAddr_i).
  - ReadPending is forced 0 for register 0 when ZERO_REG.
  - reserve to register 0 with ZERO_REG is ignored.
- Disabled: the ports and pending vector do not exist.

Decomposition:
- Package regfile_pkg:
  - typedef enum logic {RF_CLEAR, RF_RUN} rf_state_t.
  - Localparam helpers for address width.
- Sub-module regfile_clear_fsm:
  - Owns the state and the clear counter.
  - Outputs busy, clr_we and clr_addr.
  - The top muxes clr_we/clr_addr/0 onto the storage write port.
- Storage, bypass mux and scoreboard stay in register_file_mp.

Test Plan:
- Pulse reset 1 cycle, Nloc=32 -> busy=1 for exactly 32 cycles, then 0; every ReadData reads 0 afterwards.
- After clear, wr=1, WriteAddr=5, WriteData=0xDEADBEEF, ReadAddr0=5 same cycle -> ReadData0=0xDEADBEEF combinationally (bypass); next cycle with wr=0 still 0xDEADBEEF.
- ZERO_REG=1: write 0x12345678 to addr 0, then read addr 0 on all ports -> 0; with ZERO_REG=0 the same sequence reads back 0x12345678.
- Write 0xA5 to addr 3, assert reset for 1 cycle, drive wr=1 addr 3 data 0xFF during busy -> after busy falls, addr 3 reads 0.
- Assert reset again 10 cycles into the clear -> busy persists for 32 more cycles after the second reset deasserts.
- REGFILE_SCOREBOARD_EN: reserve addr 7 -> ReadPending[0]=1 for ReadAddr0=7; write addr 7 the next cycle -> ReadPending[0]=0 in the write cycle (bypass) and stays 0 afterwards.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

  // Clear-sequence controller states.
  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_t;

  localparam int unsigned RF_NLOC_DEF  = 32;
  localparam int unsigned RF_DBITS_DEF = 32;

  // Address width for a register file of nloc entries (at least 1 bit).
  function automatic int unsigned rf_aw(input int unsigned nloc);
    return (nloc > 1) ? $clog2(nloc) : 1;
  endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Post-reset clear sequencer: walks every location to zero, one per cycle,
// and holds busy until the last location has been written.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int unsigned Nloc = RF_NLOC_DEF,
  parameter int unsigned AW   = rf_aw(Nloc)
) (
  input  logic          clock,
  input  logic          reset,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] LAST = AW'(Nloc - 1);

  rf_state_t     state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  // State and counter registers; reset restarts the clear from location 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RF_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; the counter never wraps because the last location
  // hands over to RF_RUN.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy     = 1'b0;
    clr_we   = 1'b0;
    clr_addr = cnt_q;
    case (state_q)
      RF_CLEAR: begin
        busy   = 1'b1;
        clr_we = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = RF_RUN;
          cnt_d   = '0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-read-port register file with same-cycle write bypass, optional
// hardwired-zero register 0, and a sequential clear after reset.
// Optional scoreboard (pending-producer bits per register) enabled by
// defining REGFILE_SCOREBOARD_EN.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int unsigned Nloc     = RF_NLOC_DEF,
  parameter int unsigned Dbits    = RF_DBITS_DEF,
  parameter int unsigned NREAD    = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned AW       = rf_aw(Nloc)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr,
  input  logic [AW-1:0]         WriteAddr,
  input  logic [Dbits-1:0]      WriteData,
  input  logic [NREAD*AW-1:0]   ReadAddr,
  output logic [NREAD*Dbits-1:0] ReadData,
  output logic                  busy
`ifdef REGFILE_SCOREBOARD_EN
  ,
  input  logic                  reserve,
  input  logic [AW-1:0]         ReserveAddr,
  output logic [NREAD-1:0]      ReadPending
`endif
);

  localparam logic ZR = (ZERO_REG != 0);

  logic             clr_we;
  logic [AW-1:0]    clr_addr;
  logic             wr_acc;
  logic             st_we;
  logic [AW-1:0]    st_addr;
  logic [Dbits-1:0] st_data;
  logic [Dbits-1:0] rf_q [Nloc];

  regfile_clear_fsm #(
    .Nloc (Nloc),
    .AW   (AW)
  ) u_clr (
    .clock    (clock),
    .reset    (reset),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // A write lands only in RF_RUN, and never into a hardwired-zero register 0.
  assign wr_acc = wr && !busy && !reset && !(ZR && (WriteAddr == '0));

  // Single storage write port: clear sequence has priority over user writes.
  always_comb begin
    st_we   = 1'b0;
    st_addr = WriteAddr;
    st_data = WriteData;
    if (clr_we) begin
      st_we   = 1'b1;
      st_addr = clr_addr;
      st_data = '0;
    end else if (wr_acc) begin
      st_we = 1'b1;
    end
  end

  // Storage array; no reset, contents are zeroed by the clear walk.
  always_ff @(posedge clock) begin
    if (st_we) rf_q[st_addr] <= st_data;
  end

`ifdef REGFILE_SCOREBOARD_EN
  logic [Nloc-1:0] pend_q, pend_d;
  logic            rsv_acc;

  assign rsv_acc = reserve && !busy && !reset && !(ZR && (ReserveAddr == '0));

  // Pending update: a completed write clears, a new reservation sets; set wins
  // because the reservation names a newer producer.
  always_comb begin
    pend_d = pend_q;
    if (wr_acc)  pend_d[WriteAddr]   = 1'b0;
    if (rsv_acc) pend_d[ReserveAddr] = 1'b1;
  end

  // Pending vector is empty throughout reset and the clear walk.
  always_ff @(posedge clock) begin
    if (reset || busy) pend_q <= '0;
    else               pend_q <= pend_d;
  end
`endif

  for (genvar gi = 0; gi < int'(NREAD); gi++) begin : g_rd
    logic [AW-1:0]    ra;
    logic [Dbits-1:0] rd;

    assign ra = ReadAddr[gi*AW +: AW];

    // Read mux: zero register, then same-cycle bypass, then storage.
    always_comb begin
      rd = rf_q[ra];
      if (busy)                          rd = '0;
      else if (ZR && (ra == '0))         rd = '0;
      else if (wr && (WriteAddr == ra))  rd = WriteData;
    end

    assign ReadData[gi*Dbits +: Dbits] = rd;

`ifdef REGFILE_SCOREBOARD_EN
    // Pending is hidden once the producer's write is on the bus this cycle.
    assign ReadPending[gi] = !busy && !(ZR && (ra == '0)) && pend_q[ra] &&
                             !(wr && (WriteAddr == ra));
`endif
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp: two instances (ZERO_REG=1 and 0) share
// stimulus; a behavioural model predicts outputs every cycle.
module tb_register_file_mp;

  localparam int NLOC = 32;
  localparam int DB   = 32;
  localparam int NR   = 2;
  localparam int AW   = 5;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               wr = 1'b0;
  logic [AW-1:0]      wa = '0;
  logic [DB-1:0]      wd = '0;
  logic [NR*AW-1:0]   ra = '0;
  logic [NR*DB-1:0]   rd1, rd0;
  logic               busy1, busy0;
`ifdef REGFILE_SCOREBOARD_EN
  logic               reserve = 1'b0;
  logic [AW-1:0]      rsv_addr = '0;
  logic [NR-1:0]      pend1, pend0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  register_file_mp #(.Nloc(NLOC), .Dbits(DB), .NREAD(NR), .ZERO_REG(1)) u_dut (
    .clock(clock), .reset(reset), .wr(wr), .WriteAddr(wa), .WriteData(wd),
    .ReadAddr(ra), .ReadData(rd1), .busy(busy1)
`ifdef REGFILE_SCOREBOARD_EN
    , .reserve(reserve), .ReserveAddr(rsv_addr), .ReadPending(pend1)
`endif
  );

  register_file_mp #(.Nloc(NLOC), .Dbits(DB), .NREAD(NR), .ZERO_REG(0)) u_dut0 (
    .clock(clock), .reset(reset), .wr(wr), .WriteAddr(wa), .WriteData(wd),
    .ReadAddr(ra), .ReadData(rd0), .busy(busy0)
`ifdef REGFILE_SCOREBOARD_EN
    , .reserve(reserve), .ReserveAddr(rsv_addr), .ReadPending(pend0)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          mvalid = 0;
  int          clr_left = 0;
  logic [31:0] m1 [NLOC];
  logic [31:0] m0 [NLOC];
  bit          p1 [NLOC];
  bit          p0 [NLOC];

  // Model view: contents are unobservable while busy, so a reset simply
  // empties everything and starts a NLOC-cycle busy window.
  always @(posedge clock) begin
    if (reset) begin
      mvalid   = 1;
      clr_left = NLOC;
      for (int i = 0; i < NLOC; i++) begin
        m1[i] = '0; m0[i] = '0; p1[i] = 0; p0[i] = 0;
      end
    end else if (mvalid && clr_left > 0) begin
      clr_left--;
    end else if (mvalid) begin
      if (wr) begin
        m0[wa] = wd; p0[wa] = 0;
        if (wa != 0) begin m1[wa] = wd; p1[wa] = 0; end
      end
`ifdef REGFILE_SCOREBOARD_EN
      if (reserve) begin
        p0[rsv_addr] = 1;
        if (rsv_addr != 0) p1[rsv_addr] = 1;
      end
`endif
    end
  end

  function automatic logic [31:0] exp_rd(input bit z, input logic [AW-1:0] a);
    if (clr_left > 0)       return '0;
    if (z && a == 0)        return '0;
    if (wr && wa == a)      return wd;
    return z ? m1[a] : m0[a];
  endfunction

  function automatic logic exp_pend(input bit z, input logic [AW-1:0] a);
    if (clr_left > 0)       return 1'b0;
    if (z && a == 0)        return 1'b0;
    if (wr && wa == a)      return 1'b0;
    return z ? p1[a] : p0[a];
  endfunction

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clock) begin
    if (mvalid) begin
      chk("busy_z1", {31'b0, busy1}, {31'b0, clr_left > 0});
      chk("busy_z0", {31'b0, busy0}, {31'b0, clr_left > 0});
      for (int p = 0; p < NR; p++) begin
        chk("rd_z1", rd1[p*DB +: DB], exp_rd(1, ra[p*AW +: AW]));
        chk("rd_z0", rd0[p*DB +: DB], exp_rd(0, ra[p*AW +: AW]));
`ifdef REGFILE_SCOREBOARD_EN
        chk("pend_z1", {31'b0, pend1[p]}, {31'b0, exp_pend(1, ra[p*AW +: AW])});
        chk("pend_z0", {31'b0, pend0[p]}, {31'b0, exp_pend(0, ra[p*AW +: AW])});
`endif
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step;
    @(posedge clock); #1;
  endtask

  // Counts negedges with busy high; bounded so a stuck busy still finishes.
  task automatic count_busy(output int n);
    n = 0;
    repeat (100) begin
      @(negedge clock);
      if (!busy1) break;
      n++;
      @(posedge clock); #1;
    end
  endtask

  int n;

  initial begin
    // Reset, clear walk, all-zero reads.
    step;
    @(negedge clock);
    chk("reset_busy", {31'b0, busy1}, 32'd1);
    chk("reset_rd0", rd1[0 +: DB], 32'd0);
    step;
    reset = 1'b0;
    count_busy(n);
    chk("clear_len", n, 32'd32);
    step;
    for (int a = 0; a < NLOC; a++) begin
      ra = {AW'(31 - a), AW'(a)};
      @(negedge clock);
      chk("post_clear_zero", rd1[0 +: DB], 32'd0);
      step;
    end

    // Bypass then registered readback.
    wr = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; ra = {5'd9, 5'd5};
    @(negedge clock);
    chk("bypass", rd1[0 +: DB], 32'hDEADBEEF);
    step;
    wr = 1'b0;
    @(negedge clock);
    chk("stored", rd1[0 +: DB], 32'hDEADBEEF);
    step;

    // Register 0 behaviour for both variants.
    wr = 1'b1; wa = 5'd0; wd = 32'h12345678; ra = {5'd0, 5'd0};
    @(negedge clock);
    chk("z1_bypass_r0", rd1[0 +: DB], 32'd0);
    chk("z0_bypass_r0", rd0[0 +: DB], 32'h12345678);
    step;
    wr = 1'b0;
    @(negedge clock);
    chk("z1_r0_p0", rd1[0 +: DB], 32'd0);
    chk("z1_r0_p1", rd1[DB +: DB], 32'd0);
    chk("z0_r0_p0", rd0[0 +: DB], 32'h12345678);
    chk("z0_r0_p1", rd0[DB +: DB], 32'h12345678);
    step;

    // Directed write/read pattern, previous address on port 0, current on port 1.
    for (int i = 0; i < 16; i++) begin
      ra = {AW'((i * 3 + 1) % 32), wa};
      wr = 1'b1; wa = AW'((i * 3 + 1) % 32); wd = 32'h1000_0000 + i * 32'h0101;
      step;
    end
    wr = 1'b0; ra = {5'd0, 5'd4};
    @(negedge clock);
    chk("pattern_r4", rd1[0 +: DB], 32'h10000101);
    step;

    // Writes during clear are dropped.
    wr = 1'b1; wa = 5'd3; wd = 32'hA5;
    step;
    wr = 1'b0; reset = 1'b1;
    step;
    reset = 1'b0; wr = 1'b1; wa = 5'd3; wd = 32'hFF;
    repeat (32) step;
    wr = 1'b0; ra = {5'd3, 5'd3};
    @(negedge clock);
    chk("drop_in_clear_z1", rd1[0 +: DB], 32'd0);
    chk("drop_in_clear_z0", rd0[0 +: DB], 32'd0);
    step;

    // Reset mid-clear restarts the full walk.
    reset = 1'b1;
    step;
    reset = 1'b0;
    repeat (10) step;
    reset = 1'b1;
    step;
    reset = 1'b0;
    count_busy(n);
    chk("reclear_len", n, 32'd32);
    step;

`ifdef REGFILE_SCOREBOARD_EN
    reserve = 1'b1; rsv_addr = 5'd7; ra = {5'd0, 5'd7};
    step;
    reserve = 1'b0;
    @(negedge clock);
    chk("pend_set", {31'b0, pend1[0]}, 32'd1);
    step;
    wr = 1'b1; wa = 5'd7; wd = 32'h77;
    @(negedge clock);
    chk("pend_bypass", {31'b0, pend1[0]}, 32'd0);
    step;
    wr = 1'b0;
    @(negedge clock);
    chk("pend_cleared", {31'b0, pend1[0]}, 32'd0);
    step;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
